// File: rtl/cyclic_pkg.sv
// Shared types and constants for the systematic cyclic encoder.
package cyclic_pkg;

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  localparam logic [3:0] G_7_4 = 4'b1011;

endpackage

// File: rtl/lfsr_divider.sv
// Division register for the cyclic encoder: divides by GPOLY or shifts out the remainder.
module lfsr_divider #(
  parameter int         R     = 3,
  parameter logic [R:0] GPOLY = 4'b1011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  input  logic         shift_out,
  output logic [R-1:0] r
);

  logic         w_fb;
  logic [R-1:0] w_next;

  assign w_fb      = din ^ r[R-1];
  assign w_next[0] = shift_out ? 1'b0 : (w_fb & GPOLY[0]);

  // In shift_out mode the remainder drains MSB first with zeros filling from below.
  for (genvar gi = 1; gi < R; gi++) begin : g_stage
    assign w_next[gi] = shift_out ? r[gi-1] : (r[gi-1] ^ (w_fb & GPOLY[gi]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (en) begin
      r <= w_next;
    end
  end

endmodule

// File: rtl/cyclic_encoder.sv
// Serial systematic (N,K) cyclic encoder: message bits then parity, highest degree first,
// with a valid/ready handshake on the codeword stream.
module cyclic_encoder
  import cyclic_pkg::*;
#(
  parameter int             N     = 7,
  parameter int             K     = 4,
  parameter logic [N-K:0]   GPOLY = G_7_4,
  localparam int            R     = N - K,
  localparam int            CW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          msg_valid,
  input  logic [K-1:0]  msg,
  output logic          msg_ready,
  input  logic          cw_ready,
  output logic          cw_valid,
  output logic          cw_bit,
  output logic          cw_last,
  output logic [CW-1:0] count,
  output logic [R-1:0]  parity,
  output logic          parity_valid
);

  localparam logic [CW-1:0] MSG_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] CODE_LAST = CW'(N - 1);

  if (!(N > K && K >= 1)) begin : g_badSize
    $error("cyclic_encoder: need N > K >= 1");
  end
  if (GPOLY[0] != 1'b1 || GPOLY[R] != 1'b1) begin : g_badPoly
    $error("cyclic_encoder: GPOLY must have its x^0 and x^(N-K) coefficients set");
  end

  state_t        r_state, w_stateNext;
  logic [K-1:0]  r_msg;
  logic [CW-1:0] r_count;
  logic [R-1:0]  w_lfsr, w_parNext;
  logic          w_accept, w_fire, w_lastMsg, w_fb;

  assign msg_ready = (r_state == IDLE);
  assign cw_valid  = (r_state != IDLE);
  assign w_accept  = msg_ready & msg_valid;
  assign w_fire    = cw_valid & cw_ready;
  assign cw_bit    = (r_state == MSG) ? r_msg[K-1] : (r_state == PAR) ? w_lfsr[R-1] : 1'b0;
  assign cw_last   = cw_valid && (r_count == CODE_LAST);
  assign w_lastMsg = (r_state == MSG) && (r_count == MSG_LAST);
  assign count     = r_count;

  // The remainder the divider will hold after the final message bit, captured as parity.
  assign w_fb         = cw_bit ^ w_lfsr[R-1];
  assign w_parNext[0] = w_fb & GPOLY[0];
  for (genvar gi = 1; gi < R; gi++) begin : g_par
    assign w_parNext[gi] = w_lfsr[gi-1] ^ (w_fb & GPOLY[gi]);
  end

  lfsr_divider #(
    .R     (R),
    .GPOLY (GPOLY)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_accept),
    .en        (w_fire),
    .din       (cw_bit),
    .shift_out (r_state == PAR),
    .r         (w_lfsr)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (msg_valid) w_stateNext = MSG;
      MSG:     if (w_fire && r_count == MSG_LAST) w_stateNext = PAR;
      PAR:     if (w_fire && r_count == CODE_LAST) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // The message is held as a shift register so its MSB is always the bit on offer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_msg        <= '0;
      r_count      <= '0;
      parity       <= '0;
      parity_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_msg        <= msg;
        r_count      <= '0;
        parity_valid <= 1'b0;
      end else if (w_fire) begin
        r_count <= cw_last ? '0 : r_count + 1'b1;
        if (r_state == MSG) r_msg <= r_msg << 1;
      end
      if (w_fire && w_lastMsg) begin
        parity       <= w_parNext;
        parity_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cyclic_encoder.sv
// Self-checking bench for cyclic_encoder: (7,4) default instance plus a (15,11) instance,
// compared against a polynomial long-division model.
module tb_cyclic_encoder;

  logic       clk = 1'b0;
  logic       rst;

  logic       msgValid7, msgReady7, cwReady7, cwValid7, cwBit7, cwLast7, parityValid7;
  logic [3:0] msg7;
  logic [2:0] count7, parity7;

  logic        msgValid15, msgReady15, cwReady15, cwValid15, cwBit15, cwLast15, parityValid15;
  logic [10:0] msg15;
  logic [3:0]  count15, parity15;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  cyclic_encoder dut7 (
    .clk          (clk),
    .rst          (rst),
    .msg_valid    (msgValid7),
    .msg          (msg7),
    .msg_ready    (msgReady7),
    .cw_ready     (cwReady7),
    .cw_valid     (cwValid7),
    .cw_bit       (cwBit7),
    .cw_last      (cwLast7),
    .count        (count7),
    .parity       (parity7),
    .parity_valid (parityValid7)
  );

  cyclic_encoder #(.N(15), .K(11), .GPOLY(5'b10011)) dut15 (
    .clk          (clk),
    .rst          (rst),
    .msg_valid    (msgValid15),
    .msg          (msg15),
    .msg_ready    (msgReady15),
    .cw_ready     (cwReady15),
    .cw_valid     (cwValid15),
    .cw_bit       (cwBit15),
    .cw_last      (cwLast15),
    .count        (count15),
    .parity       (parity15),
    .parity_valid (parityValid15)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of a GF(2) polynomial division by plain long division.
  function automatic logic [31:0] polyRem(input logic [31:0] dividend, input int len,
                                          input logic [31:0] g, input int r);
    logic [31:0] d;
    d = dividend;
    for (int i = len - 1; i >= r; i--)
      if (d[i]) d = d ^ (g << (i - r));
    return d & ((32'd1 << r) - 32'd1);
  endfunction

  function automatic logic [31:0] encodeModel(input logic [31:0] m, input int n, input int k,
                                              input logic [31:0] g);
    logic [31:0] shifted;
    shifted = m << (n - k);
    return shifted | polyRem(shifted, n, g, n - k);
  endfunction

  // One (7,4) codeword, optionally stalling cw_ready for stallLen cycles at two bit indices.
  task automatic applyStimulus(input logic [3:0] m, input int stallA, input int stallB,
                               input int stallLen, output logic [6:0] got);
    logic heldBit;
    got = '0;
    checkOutput("ready7", msgReady7, 1);
    msgValid7 = 1'b1;
    msg7      = m;
    cwReady7  = 1'b1;
    @(negedge clk);
    msgValid7 = 1'b1;
    msg7      = ~m;
    checkOutput("latency7", cwValid7, 1);
    checkOutput("pclear7", parityValid7, 0);
    msgValid7 = 1'b0;
    for (int idx = 0; idx < 7; idx++) begin
      checkOutput("count7", count7, idx);
      checkOutput("last7", cwLast7, (idx == 6));
      if (idx == stallA || idx == stallB) begin
        cwReady7 = 1'b0;
        heldBit  = cwBit7;
        repeat (stallLen) begin
          @(negedge clk);
          checkOutput("stallBit7", cwBit7, heldBit);
          checkOutput("stallCnt7", count7, idx);
        end
        cwReady7 = 1'b1;
      end
      got[6-idx] = cwBit7;
      @(negedge clk);
      if (idx == 3) checkOutput("pvalid7", parityValid7, 1);
    end
    checkOutput("idle7", msgReady7, 1);
    checkOutput("noValid7", cwValid7, 0);
  endtask

  task automatic encodeAndCheck7(input logic [3:0] m, input int stallA, input int stallB,
                                 input int stallLen);
    logic [6:0]  got;
    logic [31:0] exp;
    exp = encodeModel(m, 7, 4, 32'b1011);
    applyStimulus(m, stallA, stallB, stallLen, got);
    checkOutput("cw7", got, exp);
    checkOutput("parity7", parity7, exp[2:0]);
    checkOutput("pkeep7", parityValid7, 1);
  endtask

  task automatic encodeAndCheck15(input logic [10:0] m);
    logic [14:0] got;
    logic [31:0] exp;
    int n, guard;
    got   = '0;
    n     = 0;
    guard = 0;
    exp   = encodeModel(m, 15, 11, 32'b10011);
    checkOutput("ready15", msgReady15, 1);
    msgValid15 = 1'b1;
    msg15      = m;
    @(negedge clk);
    msgValid15 = 1'b0;
    msg15      = 11'($urandom);
    while (n < 15 && guard < 300) begin
      cwReady15 = ($urandom_range(0, 3) != 0);
      if (cwValid15 && cwReady15) begin
        checkOutput("last15", cwLast15, (n == 14));
        got[14-n] = cwBit15;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    cwReady15 = 1'b1;
    if (guard >= 300) checkOutput("timeout15", n, 15);
    checkOutput("cw15", got, exp);
    checkOutput("div15", polyRem({17'b0, got}, 15, 32'b10011, 4), 0);
    checkOutput("parity15", parity15, exp[3:0]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0]  got;
    logic [3:0]  mNew;
    int          accCyc[$];
    logic [3:0]  accMsg[$];
    logic [6:0]  cwGot[$];
    logic [6:0]  cur;

    rst        = 1'b0;
    msgValid7  = 1'b0;
    msg7       = '0;
    cwReady7   = 1'b1;
    msgValid15 = 1'b0;
    msg15      = '0;
    cwReady15  = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rstReady", msgReady7, 1);
    checkOutput("rstValid", cwValid7, 0);
    checkOutput("rstBit", cwBit7, 0);
    checkOutput("rstLast", cwLast7, 0);
    checkOutput("rstCount", count7, 0);
    checkOutput("rstParity", parity7, 0);
    checkOutput("rstPvalid", parityValid7, 0);
    rst = 1'b1;
    @(negedge clk);

    encodeAndCheck7(4'b1101, -1, -1, 0);
    checkOutput("known1101", encodeModel(4'b1101, 7, 4, 32'b1011), 7'b1101001);
    encodeAndCheck7(4'b0001, -1, -1, 0);
    checkOutput("known0001", encodeModel(4'b0001, 7, 4, 32'b1011), 7'b0001011);
    encodeAndCheck7(4'b1000, -1, -1, 0);
    checkOutput("known1000", encodeModel(4'b1000, 7, 4, 32'b1011), 7'b1000101);
    encodeAndCheck7(4'b0000, -1, -1, 0);

    encodeAndCheck7(4'b1101, 2, 5, 3);
    for (int t = 0; t < 12; t++)
      encodeAndCheck7(4'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 3));

    // Reset in the middle of a codeword.
    msgValid7 = 1'b1;
    msg7      = 4'b1011;
    @(negedge clk);
    msgValid7 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("preRstCount", count7, 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abortValid", cwValid7, 0);
    checkOutput("abortPvalid", parityValid7, 0);
    checkOutput("abortReady", msgReady7, 1);
    checkOutput("abortCount", count7, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("quietValid", cwValid7, 0);
    end
    encodeAndCheck7(4'b0110, -1, -1, 0);

    // msg_valid held high: only values offered in IDLE get encoded.
    msgValid7 = 1'b1;
    cwReady7  = 1'b1;
    cur       = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cwValid7) begin
        cur = {cur[5:0], cwBit7};
        if (cwLast7) cwGot.push_back(cur);
      end
      mNew = 4'($urandom);
      msg7 = mNew;
      if (msgReady7) begin
        accCyc.push_back(cyc);
        accMsg.push_back(mNew);
      end
      @(negedge clk);
    end
    msgValid7 = 1'b0;
    checkOutput("accCount", accMsg.size(), 3);
    checkOutput("cwCount", cwGot.size(), 3);
    for (int i = 0; i < accMsg.size() && i < cwGot.size(); i++)
      checkOutput("streamCw", cwGot[i], encodeModel(accMsg[i], 7, 4, 32'b1011));
    for (int i = 1; i < accCyc.size(); i++)
      checkOutput("spacing", accCyc[i] - accCyc[i-1], 8);
    @(negedge clk);

    for (int t = 0; t < 20; t++)
      encodeAndCheck15(11'($urandom));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
